// File: rtl/mmu_ptw_pkg.sv
// Sv32 page-table walker shared definitions: PTE bit positions, PPN fields,
// walker state encoding and the PTE address helper.
package mmu_ptw_pkg;

  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;
  localparam int unsigned PTE_U = 4;
  localparam int unsigned PTE_G = 5;
  localparam int unsigned PTE_A = 6;
  localparam int unsigned PTE_D = 7;

  localparam int unsigned PTE_PPN_LSB  = 10;
  localparam int unsigned PTE_PPN_MSB  = 31;
  localparam int unsigned PTE_PPN0_MSB = 19;
  localparam int unsigned PTE_PPN1_LSB = 20;

  localparam int unsigned PPN_W = 22;
  localparam int unsigned VPN_W = 10;

  typedef enum logic [2:0] {
    PTW_IDLE    = 3'd0,
    PTW_L1_REQ  = 3'd1,
    PTW_L1_WAIT = 3'd2,
    PTW_L0_REQ  = 3'd3,
    PTW_L0_WAIT = 3'd4,
    PTW_DONE    = 3'd5,
    PTW_DRAIN   = 3'd6
  } ptw_state_e;

  // The VPN offset lives entirely below bit 12, so OR is carry-free addition.
  function automatic logic [33:0] pte_addr(input logic [PPN_W-1:0] ppn,
                                           input logic [VPN_W-1:0] vpn);
    return {ppn, 12'b0} | {22'b0, vpn, 2'b00};
  endfunction

endpackage

// File: rtl/mmu_pte_check_module.sv
// Combinational Sv32 PTE checker: classifies a fetched PTE as leaf / pointer
// and flags page or access faults. Superpage legality follows MMU_PTW_SUPERPAGE_EN.
module mmu_pte_check_module
  import mmu_ptw_pkg::*;
(
  input  logic [31:0] i_pte,
  input  logic        i_level,
  input  logic        i_store,
  input  logic        i_err,
  output logic        o_leaf,
  output logic        o_page_fault,
  output logic        o_access_fault
);

  logic v, r, w, x, a, d;
  logic unused_pte_bits;

  assign v = i_pte[PTE_V];
  assign r = i_pte[PTE_R];
  assign w = i_pte[PTE_W];
  assign x = i_pte[PTE_X];
  assign a = i_pte[PTE_A];
  assign d = i_pte[PTE_D];
  assign unused_pte_bits = ^{i_pte[31:8], i_pte[PTE_G], i_pte[PTE_U]};

  always_comb begin
    o_leaf         = 1'b0;
    o_page_fault   = 1'b0;
    o_access_fault = 1'b0;
    if (i_err) begin
      o_access_fault = 1'b1;
    end else if (!v || (!r && w)) begin
      o_page_fault = 1'b1;
    end else if (r || x) begin
      o_leaf = 1'b1;
      if (!a || (i_store && !d)) begin
        o_page_fault = 1'b1;
      end else if (i_level) begin
`ifdef MMU_PTW_SUPERPAGE_EN
        if (i_pte[PTE_PPN0_MSB:PTE_PPN_LSB] != '0) begin
          o_page_fault = 1'b1;
        end
`else
        o_page_fault = 1'b1;
`endif
      end
    end else if (!i_level) begin
      o_page_fault = 1'b1;
    end
  end

endmodule

// File: rtl/mmu_ptw_module.sv
// Sv32 hardware page-table walker between the L2 TLB miss and refill paths.
// Optional 4 MiB megapage support via MMU_PTW_SUPERPAGE_EN.
module mmu_ptw_module
  import mmu_ptw_pkg::*;
#(
  parameter int unsigned VADDR_WIDTH    = 32,
  parameter int unsigned PHY_ADDR_WIDTH = 34,
  parameter int unsigned PTE_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_ptw_req_vld,
  output logic                      o_ptw_req_rdy,
  input  logic [VADDR_WIDTH-1:0]    i_ptw_vaddr,
  input  logic [31:0]               i_ptw_satp,
  input  logic                      i_ptw_store,
  input  logic                      i_ptw_flush,
  output logic                      o_ptw_mem_req,
  output logic [PHY_ADDR_WIDTH-1:0] o_ptw_mem_addr,
  input  logic                      i_ptw_mem_gnt,
  input  logic                      i_ptw_mem_rsp_vld,
  input  logic [PTE_WIDTH-1:0]      i_ptw_mem_rsp_data,
  input  logic                      i_ptw_mem_rsp_err,
  output logic                      o_ptw_rsp_vld,
  output logic [PTE_WIDTH-1:0]      o_ptw_pte,
  output logic [21:0]               o_ptw_ppn,
  output logic                      o_ptw_page_fault,
  output logic                      o_ptw_access_fault
);

  ptw_state_e                state_q, state_d;
  logic [VPN_W-1:0]          vpn0_q, vpn0_d;
  logic                      store_q, store_d;
  logic [PHY_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PTE_WIDTH-1:0]      pte_q, pte_d;
  logic [PPN_W-1:0]          ppn_q, ppn_d;
  logic                      pf_q, pf_d;
  logic                      af_q, af_d;

  logic chk_leaf, chk_pf, chk_af;
  logic unused_inputs;

  assign unused_inputs = ^{i_ptw_vaddr[11:0], i_ptw_satp[31:22]};

  mmu_pte_check_module u_pte_check (
    .i_pte          (i_ptw_mem_rsp_data),
    .i_level        (state_q == PTW_L1_WAIT),
    .i_store        (store_q),
    .i_err          (i_ptw_mem_rsp_err),
    .o_leaf         (chk_leaf),
    .o_page_fault   (chk_pf),
    .o_access_fault (chk_af)
  );

  assign o_ptw_req_rdy      = (state_q == PTW_IDLE);
  assign o_ptw_mem_req      = (state_q == PTW_L1_REQ) || (state_q == PTW_L0_REQ);
  assign o_ptw_mem_addr     = addr_q;
  assign o_ptw_rsp_vld      = (state_q == PTW_DONE);
  assign o_ptw_pte          = pte_q;
  assign o_ptw_ppn          = ppn_q;
  assign o_ptw_page_fault   = pf_q;
  assign o_ptw_access_fault = af_q;

  always_comb begin
    state_d = state_q;
    vpn0_d  = vpn0_q;
    store_d = store_q;
    addr_d  = addr_q;
    pte_d   = pte_q;
    ppn_d   = ppn_q;
    pf_d    = pf_q;
    af_d    = af_q;

    case (state_q)
      PTW_IDLE: begin
        if (i_ptw_req_vld && !i_ptw_flush) begin
          vpn0_d  = i_ptw_vaddr[21:12];
          store_d = i_ptw_store;
          addr_d  = pte_addr(i_ptw_satp[21:0], i_ptw_vaddr[31:22]);
          state_d = PTW_L1_REQ;
        end
      end

      PTW_L1_REQ, PTW_L0_REQ: begin
        // A grant in the flush cycle leaves a read in flight that must be drained.
        if (i_ptw_mem_gnt) begin
          if (i_ptw_flush)                 state_d = PTW_DRAIN;
          else if (state_q == PTW_L1_REQ)  state_d = PTW_L1_WAIT;
          else                             state_d = PTW_L0_WAIT;
        end else if (i_ptw_flush) begin
          state_d = PTW_IDLE;
        end
      end

      PTW_L1_WAIT: begin
        if (i_ptw_mem_rsp_vld) begin
          if (i_ptw_flush) begin
            state_d = PTW_IDLE;
          end else if (chk_af || chk_pf) begin
            pte_d   = '0;
            ppn_d   = '0;
            pf_d    = chk_pf;
            af_d    = chk_af;
            state_d = PTW_DONE;
          end else if (chk_leaf) begin
`ifdef MMU_PTW_SUPERPAGE_EN
            pte_d = i_ptw_mem_rsp_data;
            ppn_d = {i_ptw_mem_rsp_data[PTE_PPN_MSB:PTE_PPN1_LSB], vpn0_q};
            pf_d  = 1'b0;
            af_d  = 1'b0;
`endif
            state_d = PTW_DONE;
          end else begin
            addr_d  = pte_addr(i_ptw_mem_rsp_data[PTE_PPN_MSB:PTE_PPN_LSB], vpn0_q);
            state_d = PTW_L0_REQ;
          end
        end else if (i_ptw_flush) begin
          state_d = PTW_DRAIN;
        end
      end

      PTW_L0_WAIT: begin
        if (i_ptw_mem_rsp_vld) begin
          if (i_ptw_flush) begin
            state_d = PTW_IDLE;
          end else if (chk_af || chk_pf) begin
            pte_d   = '0;
            ppn_d   = '0;
            pf_d    = chk_pf;
            af_d    = chk_af;
            state_d = PTW_DONE;
          end else begin
            pte_d   = i_ptw_mem_rsp_data;
            ppn_d   = i_ptw_mem_rsp_data[PTE_PPN_MSB:PTE_PPN_LSB];
            pf_d    = 1'b0;
            af_d    = 1'b0;
            state_d = PTW_DONE;
          end
        end else if (i_ptw_flush) begin
          state_d = PTW_DRAIN;
        end
      end

      PTW_DONE:  state_d = PTW_IDLE;

      PTW_DRAIN: begin
        if (i_ptw_mem_rsp_vld) state_d = PTW_IDLE;
      end

      default:   state_d = PTW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PTW_IDLE;
      vpn0_q  <= '0;
      store_q <= 1'b0;
      addr_q  <= '0;
      pte_q   <= '0;
      ppn_q   <= '0;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vpn0_q  <= vpn0_d;
      store_q <= store_d;
      addr_q  <= addr_d;
      pte_q   <= pte_d;
      ppn_q   <= ppn_d;
      pf_q    <= pf_d;
      af_q    <= af_d;
    end
  end

endmodule

// File: tb/tb_mmu_ptw_module.sv
// Directed self-checking bench for mmu_ptw_module; superpage expectations
// follow MMU_PTW_SUPERPAGE_EN.
module tb_mmu_ptw_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic        req_rdy;
  logic [31:0] vaddr;
  logic [31:0] satp;
  logic        store;
  logic        flush;
  logic        mem_req;
  logic [33:0] mem_addr;
  logic        gnt;
  logic        rsp_vld;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        o_vld;
  logic [31:0] o_pte;
  logic [21:0] o_ppn;
  logic        o_pf;
  logic        o_af;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bit          r_got;
  int          r_lat;
  int          r_nreq;
  logic [33:0] r_a1, r_a2;
  logic [31:0] r_pte;
  logic [21:0] r_ppn;
  logic        r_pf, r_af;

  mmu_ptw_module #(
    .VADDR_WIDTH    (32),
    .PHY_ADDR_WIDTH (34),
    .PTE_WIDTH      (32)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_ptw_req_vld      (req_vld),
    .o_ptw_req_rdy      (req_rdy),
    .i_ptw_vaddr        (vaddr),
    .i_ptw_satp         (satp),
    .i_ptw_store        (store),
    .i_ptw_flush        (flush),
    .o_ptw_mem_req      (mem_req),
    .o_ptw_mem_addr     (mem_addr),
    .i_ptw_mem_gnt      (gnt),
    .i_ptw_mem_rsp_vld  (rsp_vld),
    .i_ptw_mem_rsp_data (rsp_data),
    .i_ptw_mem_rsp_err  (rsp_err),
    .o_ptw_rsp_vld      (o_vld),
    .o_ptw_pte          (o_pte),
    .o_ptw_ppn          (o_ppn),
    .o_ptw_page_fault   (o_pf),
    .o_ptw_access_fault (o_af)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit 500000", $time);
    $fatal(1);
  end

  // Zero-wait memory: grant in the request cycle, data on the following cycle.
  task automatic do_walk(input logic [31:0] va, input logic [31:0] sp, input logic st,
                         input logic [31:0] d1, input logic e1,
                         input logic [31:0] d0, input logic e0);
    int  cyc;
    bit  pend;
    int  pidx;
    r_got = 0; r_lat = -1; r_nreq = 0; r_a1 = '0; r_a2 = '0;
    r_pte = '0; r_ppn = '0; r_pf = 1'b0; r_af = 1'b0;
    pend = 0; pidx = 0;
    @(negedge clk);
    req_vld = 1'b1; vaddr = va; satp = sp; store = st;
    @(negedge clk);
    req_vld = 1'b0;
    cyc = 1;
    while (cyc < 20 && !r_got) begin
      rsp_vld  = pend;
      rsp_data = !pend ? 32'h0 : (pidx == 1 ? d1 : d0);
      rsp_err  = !pend ? 1'b0  : (pidx == 1 ? e1 : e0);
      pend = 0;
      gnt = mem_req;
      if (mem_req) begin
        r_nreq++;
        if (r_nreq == 1) r_a1 = mem_addr; else r_a2 = mem_addr;
        pend = 1; pidx = r_nreq;
      end
      if (o_vld) begin
        r_got = 1; r_lat = cyc; r_pte = o_pte; r_ppn = o_ppn; r_pf = o_pf; r_af = o_af;
      end
      @(negedge clk);
      cyc++;
    end
    gnt = 1'b0; rsp_vld = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    total_cnt++; if (r_got !== 1'b1) $display("FAIL walk_timeout: got=%0d exp=1 (no rsp within 20 cycles)", r_got); else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 0; vaddr = '0; satp = '0; store = 0; flush = 0;
    gnt = 0; rsp_vld = 0; rsp_data = '0; rsp_err = 0;
    #12;
    total_cnt++; if (req_rdy !== 1'b1)  $display("FAIL reset_rdy: got=%b exp=1", req_rdy); else pass_cnt++;
    total_cnt++; if (mem_req !== 1'b0)  $display("FAIL reset_mem_req: got=%b exp=0", mem_req); else pass_cnt++;
    total_cnt++; if (o_vld !== 1'b0)    $display("FAIL reset_rsp_vld: got=%b exp=0", o_vld); else pass_cnt++;
    total_cnt++; if (mem_addr !== 34'h0) $display("FAIL reset_addr: got=%h exp=0", mem_addr); else pass_cnt++;
    total_cnt++; if ({o_pte, o_ppn, o_pf, o_af} !== 56'h0) $display("FAIL reset_result: got=%h exp=0", {o_pte, o_ppn, o_pf, o_af}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_walk_4k();
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h0002_0001, 1'b0, 32'h2000_00CF, 1'b0);
    total_cnt++; if (r_lat !== 5)             $display("FAIL 4k_latency: got=%0d exp=5", r_lat); else pass_cnt++;
    total_cnt++; if (r_nreq !== 2)            $display("FAIL 4k_nreq: got=%0d exp=2", r_nreq); else pass_cnt++;
    total_cnt++; if (r_a1 !== 34'h0_0008_0400) $display("FAIL 4k_l1_addr: got=%h exp=80400", r_a1); else pass_cnt++;
    total_cnt++; if (r_a2 !== 34'h0_0008_0004) $display("FAIL 4k_l0_addr: got=%h exp=80004", r_a2); else pass_cnt++;
    total_cnt++; if (r_pte !== 32'h2000_00CF) $display("FAIL 4k_pte: got=%h exp=200000cf", r_pte); else pass_cnt++;
    total_cnt++; if (r_ppn !== 22'h08_0000)   $display("FAIL 4k_ppn: got=%h exp=80000", r_ppn); else pass_cnt++;
    total_cnt++; if ({r_pf, r_af} !== 2'b00)  $display("FAIL 4k_faults: got=%b exp=00", {r_pf, r_af}); else pass_cnt++;
    total_cnt++; if (o_vld !== 1'b0 || req_rdy !== 1'b1) $display("FAIL 4k_pulse_width: got vld=%b rdy=%b exp vld=0 rdy=1", o_vld, req_rdy); else pass_cnt++;
  endtask

  task automatic test_superpage();
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h2000_00CF, 1'b0, 32'h0, 1'b0);
    total_cnt++; if (r_nreq !== 1) $display("FAIL sp_nreq: got=%0d exp=1", r_nreq); else pass_cnt++;
    total_cnt++; if (r_lat !== 3)  $display("FAIL sp_latency: got=%0d exp=3", r_lat); else pass_cnt++;
`ifdef MMU_PTW_SUPERPAGE_EN
    total_cnt++; if (r_ppn !== 22'h08_0001)   $display("FAIL sp_ppn: got=%h exp=80001", r_ppn); else pass_cnt++;
    total_cnt++; if (r_pte !== 32'h2000_00CF) $display("FAIL sp_pte: got=%h exp=200000cf", r_pte); else pass_cnt++;
    total_cnt++; if ({r_pf, r_af} !== 2'b00)  $display("FAIL sp_faults: got=%b exp=00", {r_pf, r_af}); else pass_cnt++;
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h2000_04CF, 1'b0, 32'h0, 1'b0);
    total_cnt++; if ({r_pf, r_af} !== 2'b10)  $display("FAIL sp_misaligned: got=%b exp=10", {r_pf, r_af}); else pass_cnt++;
`else
    total_cnt++; if ({r_pf, r_af} !== 2'b10)  $display("FAIL sp_disabled_fault: got=%b exp=10", {r_pf, r_af}); else pass_cnt++;
    total_cnt++; if ({r_pte, r_ppn} !== 54'h0) $display("FAIL sp_disabled_result: got=%h exp=0", {r_pte, r_ppn}); else pass_cnt++;
`endif
  endtask

  task automatic test_invalid_and_err();
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h0000_0004, 1'b0, 32'h0, 1'b0);
    total_cnt++; if ({r_pf, r_af} !== 2'b10) $display("FAIL invalid_fault: got=%b exp=10", {r_pf, r_af}); else pass_cnt++;
    total_cnt++; if (r_nreq !== 1)           $display("FAIL invalid_nreq: got=%0d exp=1", r_nreq); else pass_cnt++;
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h0002_0001, 1'b1, 32'h0, 1'b0);
    total_cnt++; if ({r_pf, r_af} !== 2'b01) $display("FAIL err_fault: got=%b exp=01", {r_pf, r_af}); else pass_cnt++;
    total_cnt++; if ({r_pte, r_ppn} !== 54'h0) $display("FAIL err_result: got=%h exp=0", {r_pte, r_ppn}); else pass_cnt++;
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h0002_0001, 1'b0, 32'h0002_0001, 1'b0);
    total_cnt++; if ({r_pf, r_af} !== 2'b10) $display("FAIL l0_nonleaf_fault: got=%b exp=10", {r_pf, r_af}); else pass_cnt++;
  endtask

  task automatic test_ad_check();
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b1, 32'h0002_0001, 1'b0, 32'h2000_004F, 1'b0);
    total_cnt++; if ({r_pf, r_af} !== 2'b10) $display("FAIL store_dirty_fault: got=%b exp=10", {r_pf, r_af}); else pass_cnt++;
    total_cnt++; if (r_pte !== 32'h0)        $display("FAIL store_dirty_pte: got=%h exp=0", r_pte); else pass_cnt++;
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h0002_0001, 1'b0, 32'h2000_004F, 1'b0);
    total_cnt++; if ({r_pf, r_af} !== 2'b00) $display("FAIL load_clean_faults: got=%b exp=00", {r_pf, r_af}); else pass_cnt++;
    total_cnt++; if (r_ppn !== 22'h08_0000)  $display("FAIL load_clean_ppn: got=%h exp=80000", r_ppn); else pass_cnt++;
    total_cnt++; if (r_pte !== 32'h2000_004F) $display("FAIL load_clean_pte: got=%h exp=2000004f", r_pte); else pass_cnt++;
  endtask

  task automatic test_flush_l0_wait();
    @(negedge clk); req_vld = 1; vaddr = 32'h4000_1234; satp = 32'h80; store = 0;
    @(negedge clk); req_vld = 0; gnt = 1;
    @(negedge clk); gnt = 0; rsp_vld = 1; rsp_data = 32'h0002_0001;
    @(negedge clk); rsp_vld = 0; rsp_data = '0;
    total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 34'h8_0004) $display("FAIL fl_l0_req: got req=%b addr=%h exp req=1 addr=80004", mem_req, mem_addr); else pass_cnt++;
    gnt = 1;
    @(negedge clk); gnt = 0; flush = 1;
    @(negedge clk); flush = 0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (req_rdy !== 1'b0 || o_vld !== 1'b0) $display("FAIL fl_drain: got rdy=%b vld=%b exp rdy=0 vld=0", req_rdy, o_vld); else pass_cnt++;
      @(negedge clk);
    end
    rsp_vld = 1; rsp_data = 32'h2000_00CF;
    total_cnt++; if (o_vld !== 1'b0) $display("FAIL fl_no_rsp: got=%b exp=0", o_vld); else pass_cnt++;
    @(negedge clk); rsp_vld = 0; rsp_data = '0;
    total_cnt++; if (req_rdy !== 1'b1 || o_vld !== 1'b0) $display("FAIL fl_idle_after: got rdy=%b vld=%b exp rdy=1 vld=0", req_rdy, o_vld); else pass_cnt++;
    do_walk(32'h4000_1234, 32'h0000_0080, 1'b0, 32'h0002_0001, 1'b0, 32'h2000_00CF, 1'b0);
    total_cnt++; if (r_ppn !== 22'h08_0000 || r_lat !== 5) $display("FAIL fl_next_walk: got ppn=%h lat=%0d exp ppn=80000 lat=5", r_ppn, r_lat); else pass_cnt++;
  endtask

  task automatic test_flush_edges();
    @(negedge clk); req_vld = 1; flush = 1; vaddr = 32'h4000_1234; satp = 32'h80;
    @(negedge clk); req_vld = 0; flush = 0;
    total_cnt++; if (req_rdy !== 1'b1 || mem_req !== 1'b0) $display("FAIL fl_accept: got rdy=%b req=%b exp rdy=1 req=0", req_rdy, mem_req); else pass_cnt++;
    req_vld = 1;
    @(negedge clk); req_vld = 0; flush = 1;
    @(negedge clk); flush = 0;
    total_cnt++; if (req_rdy !== 1'b1 || mem_req !== 1'b0) $display("FAIL fl_req_nognt: got rdy=%b req=%b exp rdy=1 req=0", req_rdy, mem_req); else pass_cnt++;
    req_vld = 1;
    @(negedge clk); req_vld = 0; flush = 1; gnt = 1;
    @(negedge clk); flush = 0; gnt = 0;
    total_cnt++; if (req_rdy !== 1'b0 || mem_req !== 1'b0) $display("FAIL fl_gnt_drain: got rdy=%b req=%b exp rdy=0 req=0", req_rdy, mem_req); else pass_cnt++;
    rsp_vld = 1; rsp_data = 32'h0002_0001;
    @(negedge clk); rsp_vld = 0; rsp_data = '0;
    total_cnt++; if (req_rdy !== 1'b1 || o_vld !== 1'b0) $display("FAIL fl_gnt_done: got rdy=%b vld=%b exp rdy=1 vld=0", req_rdy, o_vld); else pass_cnt++;
  endtask

  task automatic test_gnt_stall_reset();
    @(negedge clk); req_vld = 1; vaddr = 32'h4000_1234; satp = 32'h80; store = 0;
    @(negedge clk); req_vld = 0;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (mem_req !== 1'b1 || mem_addr !== 34'h8_0400) $display("FAIL stall_hold: got req=%b addr=%h exp req=1 addr=80400", mem_req, mem_addr); else pass_cnt++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({req_rdy, mem_req, o_vld} !== 3'b100) $display("FAIL stall_reset_ctl: got=%b exp=100", {req_rdy, mem_req, o_vld}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 34'h0) $display("FAIL stall_reset_addr: got=%h exp=0", mem_addr); else pass_cnt++;
    total_cnt++; if ({o_pte, o_ppn, o_pf, o_af} !== 56'h0) $display("FAIL stall_reset_result: got=%h exp=0", {o_pte, o_ppn, o_pf, o_af}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1; rsp_vld = 1; rsp_data = 32'h2000_00CF;
    @(negedge clk); rsp_vld = 0; rsp_data = '0;
    total_cnt++; if ({req_rdy, mem_req, o_vld} !== 3'b100) $display("FAIL late_rsp_ignored: got=%b exp=100", {req_rdy, mem_req, o_vld}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_walk_4k();
    test_superpage();
    test_invalid_and_err();
    test_ad_check();
    test_flush_l0_wait();
    test_flush_edges();
    test_gnt_stall_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
